// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
package pipe_ctrl_pkg;

  // Stage-hold mask bit positions and common masks
  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_PC   = 3'b001;
  localparam logic [2:0] HOLD_IF   = 3'b010;
  localparam logic [2:0] HOLD_ID   = 3'b100;
  localparam logic [2:0] HOLD_FLUSH = HOLD_IF | HOLD_ID;
  localparam logic [2:0] HOLD_ALL   = HOLD_PC | HOLD_IF | HOLD_ID;

  localparam logic JUMP_ENABLE  = 1'b1;
  localparam logic JUMP_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_EX_WAIT = 2'd2
  } pc_state_e;

  // Counter preload for the extra flush cycles that follow a redirect cycle.
  // The redirect cycle itself is the first flushed cycle, so the FLUSH state
  // lasts n-1 cycles and the counter counts down to zero from n-2.
  function automatic logic [1:0] flush_load(input int unsigned n);
    logic [1:0] v;
    if (n > 32'd1) begin
      v = 2'(n - 32'd2);
    end else begin
      v = 2'd0;
    end
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_chk.sv
// Protocol checker for the pipeline control unit inputs and handshake.
module pipe_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic ex_jump_req,
  input logic ex_busy,
  input logic irq_req,
  input logic irq_ack
);

  // A jump and a multi-cycle busy never arrive together from ex.
  a_no_jump_and_busy : assert property (
    @(posedge clk) disable iff (!rst) !(ex_jump_req && ex_busy)
  );

  // An acknowledge is only ever given to a pending request.
  a_ack_needs_req : assert property (
    @(posedge clk) disable iff (!rst) irq_ack |-> irq_req
  );

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline control: stage holds, PC redirects and interrupt accept.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_jump_req,
  input  logic [ADDR_W-1:0] ex_jump_addr,
  input  logic              ex_busy,
  input  logic [ADDR_W-1:0] ex_resume_addr,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              irq_req,
  input  logic [ADDR_W-1:0] irq_addr,
  output logic [2:0]        hold_flag,
  output logic              jump_flag,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              irq_ack,
  output logic [ADDR_W-1:0] irq_ret_pc,
  output logic              ex_kill
);

  // With a single flush cycle the redirect cycle covers it and no FLUSH state is needed.
  localparam bit         USE_FLUSH = (FLUSH_CYCLES > 32'd1);
  localparam logic [1:0] CNT_INIT  = flush_load(FLUSH_CYCLES);

  pc_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  // Mealy output decode and next-state selection; reset forces quiet outputs at once.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_flag  = HOLD_NONE;
    jump_flag  = JUMP_DISABLE;
    jump_addr  = {ADDR_W{1'b0}};
    irq_ack    = 1'b0;
    irq_ret_pc = {ADDR_W{1'b0}};
    ex_kill    = 1'b0;
    if (!rst) begin
      state_d = ST_IDLE;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ex_jump_req) begin
            jump_flag = JUMP_ENABLE;
            jump_addr = ex_jump_addr;
            hold_flag = HOLD_FLUSH;
            if (USE_FLUSH) begin
              state_d = ST_FLUSH;
              cnt_d   = CNT_INIT;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (ex_busy) begin
            hold_flag = HOLD_ALL;
            state_d   = ST_EX_WAIT;
          end else if (irq_req) begin
            irq_ack    = 1'b1;
            irq_ret_pc = ex_pc;
            ex_kill    = 1'b1;
            jump_flag  = JUMP_ENABLE;
            jump_addr  = irq_addr;
            hold_flag  = HOLD_FLUSH;
            if (USE_FLUSH) begin
              state_d = ST_FLUSH;
              cnt_d   = CNT_INIT;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FLUSH: begin
          // Requests wait here; ex only carries bubbles while fetch refills.
          hold_flag = HOLD_FLUSH;
          if (cnt_q == 2'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        ST_EX_WAIT: begin
          if (ex_busy) begin
            hold_flag = HOLD_ALL;
          end else begin
            jump_flag = JUMP_ENABLE;
            jump_addr = ex_resume_addr;
            hold_flag = HOLD_FLUSH;
            if (USE_FLUSH) begin
              state_d = ST_FLUSH;
              cnt_d   = CNT_INIT;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // FSM state and flush counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with a three-cycle flush.
module tb_pipe_ctrl;

  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              ex_jump_req;
  logic [ADDR_W-1:0] ex_jump_addr;
  logic              ex_busy;
  logic [ADDR_W-1:0] ex_resume_addr;
  logic [ADDR_W-1:0] ex_pc;
  logic              irq_req;
  logic [ADDR_W-1:0] irq_addr;
  logic [2:0]        hold_flag;
  logic              jump_flag;
  logic [ADDR_W-1:0] jump_addr;
  logic              irq_ack;
  logic [ADDR_W-1:0] irq_ret_pc;
  logic              ex_kill;

  int checks_cnt;
  int errors_cnt;

  pipe_ctrl #(.FLUSH_CYCLES(3), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .ex_jump_req(ex_jump_req), .ex_jump_addr(ex_jump_addr),
    .ex_busy(ex_busy), .ex_resume_addr(ex_resume_addr), .ex_pc(ex_pc),
    .irq_req(irq_req), .irq_addr(irq_addr),
    .hold_flag(hold_flag), .jump_flag(jump_flag), .jump_addr(jump_addr),
    .irq_ack(irq_ack), .irq_ret_pc(irq_ret_pc), .ex_kill(ex_kill)
  );

  pipe_ctrl_chk u_chk (
    .clk(clk), .rst(rst), .ex_jump_req(ex_jump_req), .ex_busy(ex_busy),
    .irq_req(irq_req), .irq_ack(irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output right now, without advancing time.
  task automatic cmp_now(input string tag, input logic [2:0] hold, input logic jf,
                         input logic [31:0] ja, input logic ack, input logic [31:0] rpc,
                         input logic kill);
    check({tag, ".hold"}, {29'd0, hold_flag}, {29'd0, hold});
    check({tag, ".jf"}, {31'd0, jump_flag}, {31'd0, jf});
    check({tag, ".ja"}, jump_addr, ja);
    check({tag, ".ack"}, {31'd0, irq_ack}, {31'd0, ack});
    check({tag, ".rpc"}, irq_ret_pc, rpc);
    check({tag, ".kill"}, {31'd0, ex_kill}, {31'd0, kill});
  endtask

  // Sample on the falling edge, then move to just after the next rising edge.
  task automatic cyc(input string tag, input logic [2:0] hold, input logic jf,
                     input logic [31:0] ja, input logic ack, input logic [31:0] rpc,
                     input logic kill);
    @(negedge clk);
    cmp_now(tag, hold, jf, ja, ack, rpc, kill);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks_cnt     = 0;
    errors_cnt     = 0;
    rst            = 1'b0;
    ex_jump_req    = 1'b1;
    ex_jump_addr   = 32'h0000_0999;
    ex_busy        = 1'b0;
    ex_resume_addr = 32'h0;
    ex_pc          = 32'h0000_0040;
    irq_req        = 1'b0;
    irq_addr       = 32'h0000_0080;

    // Reset held with a request present: outputs stay quiet.
    cyc("rst", 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    ex_jump_req = 1'b0;
    cyc("rst2", 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) cyc("idle", 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Branch redirect followed by two FLUSH cycles.
    ex_jump_req = 1'b1; ex_jump_addr = 32'h0000_0100;
    cyc("jmp", 3'b110, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    ex_jump_req = 1'b0;
    cyc("jfl1", 3'b110, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc("jfl2", 3'b110, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc("jend", 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Multi-cycle op; a pending irq loses to busy and waits out EX_WAIT.
    ex_busy = 1'b1; irq_req = 1'b1; ex_resume_addr = 32'h0000_0024;
    for (int i = 0; i < 5; i++) cyc("busy", 3'b111, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    ex_busy = 1'b0; irq_req = 1'b0;
    cyc("resume", 3'b110, 1'b1, 32'h24, 1'b0, 32'h0, 1'b0);
    cyc("rfl1", 3'b110, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc("rfl2", 3'b110, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc("rend", 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Interrupt accept; level stays high through FLUSH without a second ack.
    irq_req = 1'b1; irq_addr = 32'h0000_0080; ex_pc = 32'h0000_0040;
    cyc("irq", 3'b110, 1'b1, 32'h80, 1'b1, 32'h40, 1'b1);
    cyc("ifl1", 3'b110, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc("ifl2", 3'b110, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    irq_req = 1'b0;
    cyc("iend", 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Jump beats irq; irq taken on first IDLE cycle after the flush.
    ex_jump_req = 1'b1; ex_jump_addr = 32'h0000_0200; irq_req = 1'b1; ex_pc = 32'h0000_0300;
    cyc("jvi", 3'b110, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    ex_jump_req = 1'b0;
    cyc("jvfl1", 3'b110, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc("jvfl2", 3'b110, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc("jvirq", 3'b110, 1'b1, 32'h80, 1'b1, 32'h300, 1'b1);
    irq_req = 1'b0;
    cyc("jvfl3", 3'b110, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc("jvfl4", 3'b110, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc("jvend", 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Reset pulled during EX_WAIT drops outputs immediately.
    ex_busy = 1'b1; ex_resume_addr = 32'h0000_0055;
    cyc("wbusy1", 3'b111, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc("wbusy2", 3'b111, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    cmp_now("rstw", 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    ex_busy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc("postrst", 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline control unit. Produces the stage-hold mask consumed by the pc, if_id and id_ex pipeline registers, and the PC redirect (jump) for the fetch stage.
- Arbitrates three sources: branch/jump requests from ex, multi-cycle ex operations (divider), and interrupt requests from the interrupt controller.
- Holds a small FSM that stretches flushes across the fetch latency and resumes after multi-cycle operations.

Parameters:
- FLUSH_CYCLES, 1, cycles IF/ID stay flushed after any redirect; legal range 1..4.
- ADDR_W, 32, instruction address width; equals `InstAddrBus width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low (rst==0 resets)
- ex_jump_req  in  1  ex resolved a taken branch/jump this cycle
- ex_jump_addr  in  ADDR_W  target for ex_jump_req
- ex_busy  in  1  ex multi-cycle operation in progress (level)
- ex_resume_addr  in  ADDR_W  address of instruction after the busy one; valid on the cycle ex_busy falls
- ex_pc  in  ADDR_W  pc of the instruction currently in ex
- irq_req  in  1  interrupt request (level, held until irq_ack)
- irq_addr  in  ADDR_W  interrupt vector
- hold_flag  out  `HoldFlagBus (3)  bit0 HoldPc: pc keeps value; bit1 HoldIf: if_id loads NOP; bit2 HoldId: id_ex loads NOP
- jump_flag  out  1  pc loads jump_addr next edge
- jump_addr  out  ADDR_W  redirect target
- irq_ack  out  1  one-cycle accept pulse to interrupt source
- irq_ret_pc  out  ADDR_W  return pc for mepc (= ex_pc at accept)
- ex_kill  out  1  suppress ex register/memory writes this cycle

Behaviour:
- Outputs are Mealy: a combinational decode of the registered state plus current inputs, so holds act on the same edge as the request. The FSM state and counter are registered.
- Reset (rst==0, async): state=IDLE, cnt=0.
- Outputs while in reset or when idle with no request: hold_flag=3'b000, jump_flag=0, jump_addr=0, irq_ack=0, irq_ret_pc=0, ex_kill=0.
- States: IDLE, FLUSH, EX_WAIT. cnt is 2 bits.
- IDLE priority (highest first): ex_jump_req, then ex_busy, then irq_req.
  - ex_jump_req: jump_flag=1, jump_addr=ex_jump_addr, hold_flag=3'b110. If FLUSH_CYCLES>1: go to FLUSH with cnt=FLUSH_CYCLES-2. Otherwise stay in IDLE.
  - ex_busy: hold_flag=3'b111; go to EX_WAIT.
  - irq_req: irq_ack=1, irq_ret_pc=ex_pc, ex_kill=1, jump_flag=1, jump_addr=irq_addr, hold_flag=3'b110. Next state as for a jump.
- FLUSH: hold_flag=3'b110, no jump. If cnt==0 go to IDLE, else decrement cnt. ex_jump_req, ex_busy and irq_req are ignored here; ex only holds bubbles, and irq_req stays pending.
- EX_WAIT:
  - While ex_busy=1: hold_flag=3'b111.
  - On the cycle ex_busy=0: jump_flag=1, jump_addr=ex_resume_addr, hold_flag=3'b110. Next state as for a jump.
  - irq_req is not accepted while in EX_WAIT.
- Simultaneous ex_jump_req and ex_busy in IDLE: the jump wins and busy is ignored that cycle. This combination is a protocol violation and is checked by an assertion.
- irq_ack is exactly one cycle per accepted interrupt. No second ack until irq_req has been seen low, or is re-sampled in IDLE after the FLUSH completes.
- Reset mid-FLUSH or mid-EX_WAIT forces IDLE immediately. Outputs drop asynchronously.

Decomposition:
- Shared defines.v: HoldFlagBus [2:0]; HoldPc 3'b001; HoldIf 3'b010; HoldId 3'b100; HoldNone 3'b000; JumpEnable/Disable; state encodings.
- No sub-module. FSM and counter live in one always block; output decode is a single combinational block.

Test Plan:
- Reset release, no requests → hold_flag=000, jump_flag=0 for 10 cycles.
- FLUSH_CYCLES=3, ex_jump_req=1 with addr=0x100 for one cycle → that cycle: jump_flag=1, jump_addr=0x100, hold=110. Next 2 cycles: hold=110, jump_flag=0. Then hold=000.
- ex_busy high 5 cycles then low with ex_resume_addr=0x24 → hold=111 for 5 cycles. Fall cycle: jump_flag=1, jump_addr=0x24, hold=110.
- irq_req=1, irq_addr=0x80, ex_pc=0x40 while idle → one-cycle irq_ack=1, irq_ret_pc=0x40, ex_kill=1, jump to 0x80. No second ack while in FLUSH.
- irq_req and ex_jump_req same cycle → jump taken, irq_ack=0. irq accepted on the first IDLE cycle after the flush completes.
- rst pulled low during EX_WAIT → hold_flag=000 immediately. After release, state is IDLE and ex_busy=0 produces no jump.
